fp16_align_unpack: RTL and testbench

- Front end of the FP16 add/sub datapath: unpacks two half-precision operands and compares exponents.
- Right-shifts the smaller-exponent mantissa until both share one exponent.
- Hands aligned 11-bit mantissas plus the common exponent (exp_base) to the mantissa adder, whose 12-bit result feeds the normalization stage.
- Default implementation is an iterative 1-bit-per-cycle shifter with valid/ready handshakes on both sides.

---
 rtl/fp16_align_unpack.sv | 110 +++++++++++
 tb/tb_fp16_align_unpack.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fp16_align_unpack.sv
// FP16 add/sub front end: unpacks two operands, swaps by exponent and aligns the smaller mantissa.
// Optional macro ALIGN_BARREL_EN replaces the 1-bit-per-cycle shifter with a single-cycle barrel shift.
module fp16_align_unpack #(
  parameter int MAN_W = 11,
  parameter int EXP_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W-1:0] man_big,
  output logic [MAN_W-1:0] man_small,
  output logic             sign_big,
  output logic             sign_small,
  output logic [EXP_W-1:0] exp_base,
  output logic             eff_sub,
  output logic             special
);

  localparam int CNT_W = $clog2(MAN_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;

  logic [EXP_W-1:0] exp_a, exp_b, exp_big, exp_sml, diff;
  logic [MAN_W-1:0] man_a, man_b, man_big_c, man_sml_c;
  logic             a_big, drop;

`ifndef ALIGN_BARREL_EN
  logic [CNT_W-1:0] cnt;
`endif

  always_comb begin
    exp_a     = op_a[MAN_W-1 +: EXP_W];
    exp_b     = op_b[MAN_W-1 +: EXP_W];
    man_a     = (exp_a == '0) ? '0 : {1'b1, op_a[MAN_W-2:0]};
    man_b     = (exp_b == '0) ? '0 : {1'b1, op_b[MAN_W-2:0]};
    a_big     = (exp_a >= exp_b);
    exp_big   = a_big ? exp_a : exp_b;
    exp_sml   = a_big ? exp_b : exp_a;
    man_big_c = a_big ? man_a : man_b;
    man_sml_c = a_big ? man_b : man_a;
    diff      = exp_big - exp_sml;
    // Zero small operand or a shift past the whole mantissa both flush to 0 with no shift cycles.
    drop      = (exp_sml == '0) || (diff >= EXP_W'(MAN_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      man_big    <= '0;
      man_small  <= '0;
      sign_big   <= 1'b0;
      sign_small <= 1'b0;
      exp_base   <= '0;
      eff_sub    <= 1'b0;
      special    <= 1'b0;
`ifndef ALIGN_BARREL_EN
      cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready   <= 1'b0;
            man_big    <= man_big_c;
            sign_big   <= a_big ? op_a[15] : op_b[15];
            sign_small <= a_big ? op_b[15] : op_a[15];
            eff_sub    <= op_a[15] ^ op_b[15];
            exp_base   <= exp_big;
            special    <= (exp_a == '1) || (exp_b == '1);
`ifdef ALIGN_BARREL_EN
            man_small  <= drop ? '0 : (man_sml_c >> diff);
            state      <= DONE;
`else
            man_small  <= drop ? '0 : man_sml_c;
            cnt        <= drop ? '0 : diff[CNT_W-1:0];
            state      <= (drop || diff == '0) ? DONE : SHIFT;
`endif
          end
        end
`ifndef ALIGN_BARREL_EN
        SHIFT: begin
          man_small <= man_small >> 1;
          cnt       <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= DONE;
        end
`endif
        DONE: begin
          // First DONE cycle raises out_valid; results are already settled.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_align_unpack.sv
// Directed plus random scoreboard bench for fp16_align_unpack (both ALIGN_BARREL_EN builds).
module tb_fp16_align_unpack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] man_big;
  logic [10:0] man_small;
  logic        sign_big;
  logic        sign_small;
  logic [4:0]  exp_base;
  logic        eff_sub;
  logic        special;

  always #5 clk = ~clk;

  fp16_align_unpack #(.MAN_W(11), .EXP_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .man_big    (man_big),
    .man_small  (man_small),
    .sign_big   (sign_big),
    .sign_small (sign_small),
    .exp_base   (exp_base),
    .eff_sub    (eff_sub),
    .special    (special)
  );

  typedef struct {
    logic [10:0] mb;
    logic [10:0] ms;
    logic        sb;
    logic        ss;
    logic [4:0]  eb;
    logic        es;
    logic        sp;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [10:0] mb, input logic [10:0] ms, input logic sb,
                              input logic ss, input logic [4:0] eb, input logic sp, input int n);
    exp_t e;
    e.mb = mb; e.ms = ms; e.sb = sb; e.ss = ss; e.eb = eb;
    e.es = sb ^ ss;
    e.sp = sp;
`ifdef ALIGN_BARREL_EN
    e.lat = 1;
`else
    e.lat = n + 1;
`endif
    return e;
  endfunction

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  ea, eb, ebig, esml, d;
    logic [10:0] ma, mbb, mbig, msml, ms;
    logic        sb, ss;
    int          n;
    ea  = a[14:10];
    eb  = b[14:10];
    ma  = (ea == 5'd0) ? 11'd0 : {1'b1, a[9:0]};
    mbb = (eb == 5'd0) ? 11'd0 : {1'b1, b[9:0]};
    if (ea >= eb) begin
      ebig = ea; esml = eb; mbig = ma; msml = mbb; sb = a[15]; ss = b[15];
    end else begin
      ebig = eb; esml = ea; mbig = mbb; msml = ma; sb = b[15]; ss = a[15];
    end
    d = ebig - esml;
    if (esml == 5'd0 || d >= 5'd11) begin
      ms = 11'd0; n = 0;
    end else begin
      ms = msml >> d; n = int'(d);
    end
    return mk(mbig, ms, sb, ss, ebig, (ea == 5'd31) || (eb == 5'd31), n);
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".man_big"}, 32'(man_big), 32'(e.mb));
    check({tag, ".man_small"}, 32'(man_small), 32'(e.ms));
    check({tag, ".sign_big"}, 32'(sign_big), 32'(e.sb));
    check({tag, ".sign_small"}, 32'(sign_small), 32'(e.ss));
    check({tag, ".exp_base"}, 32'(exp_base), 32'(e.eb));
    check({tag, ".eff_sub"}, 32'(eff_sub), 32'(e.es));
    check({tag, ".special"}, 32'(special), 32'(e.sp));
  endtask

  // Drive one operand pair, measure latency from the accept edge, compare, then hold and release.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input exp_t e, input int hold);
    int   lat;
    exp_t got;
    sbq.push_back(e);
    lat = 0;
    while (!in_ready && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
    op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1; lat++;
    end
    got = sbq.pop_front();
    check({tag, ".latency"}, 32'(lat), 32'(got.lat));
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check_outputs(tag, got);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
      check_outputs({tag, ".hold"}, got);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
    check_outputs({tag, ".post"}, got);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          w;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check_outputs("rst", mk(11'd0, 11'd0, 1'b0, 1'b0, 5'd0, 1'b0, 0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel.in_ready", 32'(in_ready), 32'd1);

    run_op("basic",   16'h3C00, 16'h3800, mk(11'h400, 11'h200, 1'b0, 1'b0, 5'd15, 1'b0, 1), 0);
    run_op("swap",    16'h3800, 16'hBC00, mk(11'h400, 11'h200, 1'b1, 1'b0, 5'd15, 1'b0, 1), 0);
    run_op("eqexp",   16'h3C00, 16'hBC00, mk(11'h400, 11'h400, 1'b0, 1'b1, 5'd15, 1'b0, 0), 0);
    run_op("far",     16'h7000, 16'h3C00, mk(11'h400, 11'h000, 1'b0, 1'b0, 5'd28, 1'b0, 0), 0);
    run_op("zero",    16'h7000, 16'h0000, mk(11'h400, 11'h000, 1'b0, 1'b0, 5'd28, 1'b0, 0), 0);
    run_op("diff10",  16'h4C00, 16'h2401, mk(11'h400, 11'h001, 1'b0, 1'b0, 5'd19, 1'b0, 10), 0);
    run_op("special", 16'h7C00, 16'h3C00, mk(11'h400, 11'h000, 1'b0, 1'b0, 5'd31, 1'b1, 0), 5);

    // Reset during the 4th shift cycle of a diff-10 operation.
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    op_a = 16'h4C00; op_b = 16'h2401; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    check_outputs("midrst", mk(11'd0, 11'd0, 1'b0, 1'b0, 5'd0, 1'b0, 0));
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst.rel_in_ready", 32'(in_ready), 32'd1);
    check("midrst.rel_out_valid", 32'(out_valid), 32'd0);
    run_op("after_rst", 16'h4C00, 16'h2401, mk(11'h400, 11'h001, 1'b0, 1'b0, 5'd19, 1'b0, 10), 0);

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom_range(0, 16'hFFFF));
      if (i == 0) rb = {~ra[15], ra[14:10] - 5'd3, rb[9:0]};
      run_op("random", ra, rb, model(ra, rb), i % 2);
    end

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
